// File: rtl/pingpong_pkg.sv
// Shared types and default sizing for the ping-pong swap buffer.
// Optional swap counter is enabled by defining PPBUF_SWAP_CNT_EN.
package pingpong_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 8;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      BOTH = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/pp_bank.sv
// One DEPTH x WIDTH storage bank: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module pp_bank #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pingpong_swap_buf.sv
// Two-bank ping-pong buffer: the writer fills one bank while the reader drains the other.
// Define PPBUF_SWAP_CNT_EN to add the 16-bit swap_cnt output.
module pingpong_swap_buf
   import pingpong_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
`ifdef PPBUF_SWAP_CNT_EN
   ,
   output logic [15:0]      swap_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t          state_reg;
   logic            wsel_reg;
   logic [CW-1:0]   wcnt_reg;
   logic [CW-1:0]   rcnt_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   wcnt_next;
   logic [CW-1:0]   rcnt_next;
   logic            wr_fire;
   logic            rd_fire;
   logic            swap;
   logic [WIDTH-1:0] bank_rdata [2];

   assign wr_ready  = (wcnt_reg < FULL);
   assign rd_valid  = (rcnt_reg != '0);
   assign wr_fire   = wr_valid && wr_ready;
   assign rd_fire   = rd_valid && rd_ready;
   assign wcnt_next = wcnt_reg + {{(CW-1){1'b0}}, wr_fire};
   assign rcnt_next = rcnt_reg - {{(CW-1){1'b0}}, rd_fire};

   // FILL implies an empty read bank and HOLD a full write bank, so either
   // state alone tells which counter still gates the swap.
   assign swap = ((state_reg == FILL) && (wcnt_reg == FULL)) ||
                 ((state_reg == HOLD) && (rcnt_reg == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= FILL;
         wsel_reg   <= 1'b0;
         wcnt_reg   <= '0;
         rcnt_reg   <= '0;
         rd_ptr_reg <= '0;
      end else if (swap) begin
         state_reg  <= BOTH;
         wsel_reg   <= ~wsel_reg;
         wcnt_reg   <= '0;
         rcnt_reg   <= FULL;
         rd_ptr_reg <= '0;
      end else begin
         wcnt_reg <= wcnt_next;
         rcnt_reg <= rcnt_next;
         if (rd_fire) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case (state_reg)
            BOTH: begin
               if (wcnt_next == FULL) begin
                  state_reg <= HOLD;
               end else if (rcnt_next == '0) begin
                  state_reg <= FILL;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      pp_bank #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_bank (
         .clk   (clk),
         .we    (wr_fire && (wsel_reg == 1'(gi))),
         .waddr (wcnt_reg[AW-1:0]),
         .wdata (wr_data),
         .raddr (rd_ptr_reg),
         .rdata (bank_rdata[gi])
      );
   end

   assign rd_data = bank_rdata[~wsel_reg];

`ifdef PPBUF_SWAP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swap_cnt <= 16'd0;
      end else if (swap) begin
         swap_cnt <= swap_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pingpong_swap_buf.sv
// Self-checking bench for pingpong_swap_buf (default WIDTH=32, DEPTH=8).
// Checks swap_cnt too when PPBUF_SWAP_CNT_EN is defined.
module tb_pingpong_swap_buf;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_valid;
   logic             rd_ready = 1'b0;
   logic [WIDTH-1:0] rd_data;
`ifdef PPBUF_SWAP_CNT_EN
   logic [15:0]      swap_cnt;
`endif

   pingpong_swap_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data)
`ifdef PPBUF_SWAP_CNT_EN
      ,
      .swap_cnt (swap_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the write bank and read bank as word queues.
   logic [WIDTH-1:0] wq[$];
   logic [WIDTH-1:0] rq[$];
   logic [15:0]      m_swaps;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      wq.delete();
      rq.delete();
      m_swaps = 16'd0;
   endtask

   // Compare against the model, apply one clock edge, advance the model.
   task automatic tick(input logic wv, input logic rr, input logic [WIDTH-1:0] wd);
      logic m_wf;
      logic m_rf;
      wr_valid = wv;
      rd_ready = rr;
      wr_data  = wd;
      chk("wr_ready", 32'(wr_ready), 32'(wq.size() < DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(rq.size() != 0));
      if (rq.size() != 0) chk("rd_data", rd_data, rq[0]);
`ifdef PPBUF_SWAP_CNT_EN
      chk("swap_cnt", 32'(swap_cnt), 32'(m_swaps));
`endif
      @(posedge clk);
      if (wq.size() == DEPTH && rq.size() == 0) begin
         rq = wq;
         wq.delete();
         m_swaps = m_swaps + 16'd1;
         $display("swap #%0d", m_swaps);
      end else begin
         m_wf = wv && (wq.size() < DEPTH);
         m_rf = rr && (rq.size() != 0);
         if (m_wf) begin
            wq.push_back(wd);
            $display("wr %08h", wd);
         end
         if (m_rf) begin
            $display("rd %08h", rq[0]);
            void'(rq.pop_front());
         end
      end
      #1;
   endtask

   // Asynchronous reset asserted between edges; outputs checked before any edge.
   task automatic do_reset();
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifdef PPBUF_SWAP_CNT_EN
      chk("rst_swap_cnt", 32'(swap_cnt), 32'd0);
`endif
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("reset done");
   endtask

   typedef struct {
      logic             wv;
      logic             rr;
      logic [WIDTH-1:0] wd;
      logic             exp_wr_ready;
      logic             exp_rd_valid;
      logic             chk_data;
      logic [WIDTH-1:0] exp_rd_data;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [WIDTH-1:0] saved[DEPTH];
      int sent;
      int got;

      // Fill 1..8 with reader stalled, then watch the swap and first reads.
      for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 1'b0, 32'(i + 1), 1'b1, 1'b0, 1'b0, 32'd0};
      vecs[8]  = '{1'b1, 1'b0, 32'h99, 1'b0, 1'b0, 1'b0, 32'd0};
      vecs[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd1};
      vecs[10] = '{1'b0, 1'b1, 32'd0,  1'b1, 1'b1, 1'b1, 32'd1};
      vecs[11] = '{1'b0, 1'b1, 32'd0,  1'b1, 1'b1, 1'b1, 32'd2};

      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 12; i++) begin
         chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_wr_ready));
         chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rd_valid));
         if (vecs[i].chk_data) chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd_data);
         tick(vecs[i].wv, vecs[i].rr, vecs[i].wd);
      end

      // Continuous streaming of 24 words.
      do_reset();
      sent = 0;
      got  = 0;
      for (int c = 0; c < 200 && got < 24; c++) begin
         if (rd_valid) begin
            chk("stream_data", rd_data, 32'(got + 1));
            got++;
         end
         if (sent < 24 && wq.size() < DEPTH && !(wq.size() == DEPTH && rq.size() == 0)) begin
            tick(1'b1, 1'b1, 32'(sent + 1));
            sent++;
         end else begin
            tick(1'b0, 1'b1, 32'd0);
         end
      end
      chk("stream_len", 32'(got), 32'd24);
`ifdef PPBUF_SWAP_CNT_EN
      chk("stream_swaps", 32'(swap_cnt), 32'd3);
`endif

      // Full write bank, one word left in the read bank: one-cycle bubble.
      do_reset();
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'(i + 1));
      tick(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) tick(1'b1, (i < 7), 32'(i + 9));
      chk("last_wr_ready", 32'(wr_ready), 32'd0);
      chk("last_rd_valid", 32'(rd_valid), 32'd1);
      chk("last_rd_data", rd_data, 32'd8);
      tick(1'b0, 1'b1, 32'd0);
      chk("bubble_rd_valid", 32'(rd_valid), 32'd0);
      chk("bubble_wr_ready", 32'(wr_ready), 32'd0);
      tick(1'b0, 1'b0, 32'd0);
      chk("post_swap_wr_ready", 32'(wr_ready), 32'd1);
      chk("post_swap_rd_valid", 32'(rd_valid), 32'd1);
      chk("post_swap_rd_data", rd_data, 32'd9);

      // Partial bank never becomes readable.
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'(i + 100));
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 32'd0);
      chk("partial_rd_valid", 32'(rd_valid), 32'd0);
      chk("partial_wr_ready", 32'(wr_ready), 32'd1);

      // Asynchronous reset mid-drain, then a clean refill.
      do_reset();
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'(i + 200));
      tick(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'd0);
      chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         saved[i] = $urandom;
         tick(1'b1, 1'b0, saved[i]);
      end
      tick(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("refill_rd_data", rd_data, saved[i]);
         tick(1'b0, 1'b1, 32'd0);
      end
      chk("refill_empty", 32'(rd_valid), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         tick(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      end
      for (int i = 0; i < 200; i++) begin
         tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
